stage_id: RTL and testbench
===========================

Name: stage_ID

Overview:
- Instruction-decode stage, directly downstream of stage_IF.
- Captures the fetched instruction and PC into an internal IF/ID register.
- Decodes RV32I, reads a 32x32 register file, generates immediates, and detects load-use hazards.
- Registers results into an ID/EX register for the execute stage. Drives pc_en and stall_en back to stage_IF.

Parameters:
addr_width, 32, width of PC / instruction-memory address
word_width, 32, data and instruction width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
inst  input  word_width  fetched instruction from stage_IF
pc_addr  input  addr_width  PC of inst
flush  input  1  branch/jump taken in EX; kill younger instructions
wb_en  input  1  register-file write enable from writeback
wb_rd  input  5  writeback destination register
wb_data  input  word_width  writeback data
pc_en  output  1  PC update enable to stage_IF
stall_en  output  1  stage_IF substitutes NOP for its instruction
id_valid  output  1  ID/EX holds a real instruction
id_pc  output  addr_width  PC of the instruction in ID/EX
id_rs1_data  output  word_width  rs1 operand
id_rs2_data  output  word_width  rs2 operand
id_imm  output  word_width  sign-extended immediate
id_rs1  output  5  rs1 index (for EX forwarding)
id_rs2  output  5  rs2 index
id_rd  output  5  destination register
id_funct3  output  3  funct3
id_funct7b5  output  1  inst[30]
id_opcode  output  7  opcode
id_reg_write  output  1  writes rd (forced 0 when rd==0)
id_mem_read  output  1  load
id_mem_write  output  1  store
id_branch  output  1  conditional branch
id_jump  output  1  JAL or JALR
id_illegal  output  1  unrecognised opcode

Behaviour:
- Reset (rst=0, asynchronous):
  - IF/ID: NOP (0x00000013), PC 0, valid 0.
  - ID/EX: every output 0.
  - All 32 registers cleared.
- Latency: inst/pc_addr captured at edge N; decoded values visible on id_* after edge N+1.
- Register file:
  - Write on rising edge when wb_en && wb_rd!=0.
  - x0 always reads 0.
  - Reads are combinational from the IF/ID fields.
  - Write-through: if wb_en && wb_rd==rsX && rsX!=0, the read returns wb_data in the same cycle.
- Decode:
  - Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Immediate types:
    - I: OP-IMM, LOAD, JALR.
    - S: STORE.
    - B: BRANCH, bit0=0.
    - U: LUI/AUIPC, low 12 bits zero.
    - J: JAL, bit0=0.
  - Others: imm=0.
  - Any other opcode: id_illegal=1, all control bits 0, id_valid=1.
- Source use:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
- Load-use hazard (combinational):
  - Condition: id_valid && id_mem_read && id_rd!=0 && id_rd equals a used source of the IF/ID instruction.
  - Response: pc_en=0, IF/ID holds, ID/EX loads a bubble (all zero, id_valid=0).
  - Stall lasts exactly one cycle, then the instruction proceeds.
- Flush:
  - stall_en = flush.
  - On the edge: IF/ID loads NOP with valid=0, and ID/EX loads a bubble.
  - pc_en=1, so stage_IF takes the branch target.
  - Flush overrides a simultaneous load-use hazard.
- Normal operation: pc_en=1, and both pipeline registers advance every cycle.
- Reset mid-stall or mid-flush: all state returns to reset values immediately; no pending stall survives.

Test Plan:
- Reset: hold rst=0, present random inst -> all id_* 0, pc_en=1, reading x5 returns 0; release -> first instruction appears on id_* after 2 edges.
- Decode: inst=0xFFF08093 (addi x1,x1,-1) at pc 0x40 -> id_imm=0xFFFFFFFF, id_rd=1, id_reg_write=1, id_pc=0x40. inst=0xFE000EE3 (beq x0,x0,-4) -> id_imm=0xFFFFFFFC, id_branch=1, id_reg_write=0.
- Write-through: wb_en=1, wb_rd=3, wb_data=0xDEADBEEF while add x4,x3,x0 is in IF/ID -> id_rs1_data=0xDEADBEEF; wb_rd=0 with data 5 -> x0 still reads 0.
- Load-use: lw x2,0(x1) followed by add x3,x2,x2:
  - One cycle with pc_en=0 and id_valid=0.
  - add then appears with id_rs1=2.
  - With add x3,x4,x5 instead: no stall.
- Flush:
  - flush=1 for one cycle -> stall_en=1, pc_en=1.
  - Next id_valid=0, and the following cycle's id_valid is also 0.
  - flush together with a load-use hazard -> pc_en=1 and both bubbles inserted.
- Async reset asserted mid-stall -> outputs clear without waiting for a clock edge; after release, the pipeline restarts with no residual stall.

Source files
------------

// File: rtl/stage_id.sv
// stage_id: RV32I decode stage with IF/ID and ID/EX registers, a 32x32 register file
// with write-through, immediate generation and load-use hazard detection.
module stage_id #(
  parameter int addr_width = 32,
  parameter int word_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] inst,
  input  logic [addr_width-1:0] pc_addr,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [4:0]            wb_rd,
  input  logic [word_width-1:0] wb_data,
  output logic                  pc_en,
  output logic                  stall_en,
  output logic                  id_valid,
  output logic [addr_width-1:0] id_pc,
  output logic [word_width-1:0] id_rs1_data,
  output logic [word_width-1:0] id_rs2_data,
  output logic [word_width-1:0] id_imm,
  output logic [4:0]            id_rs1,
  output logic [4:0]            id_rs2,
  output logic [4:0]            id_rd,
  output logic [2:0]            id_funct3,
  output logic                  id_funct7b5,
  output logic [6:0]            id_opcode,
  output logic                  id_reg_write,
  output logic                  id_mem_read,
  output logic                  id_mem_write,
  output logic                  id_branch,
  output logic                  id_jump,
  output logic                  id_illegal
);
  localparam logic [word_width-1:0] nop = 32'h0000_0013;
  localparam logic [6:0] op_lui = 7'b0110111, op_auipc = 7'b0010111, op_jal = 7'b1101111,
                         op_jalr = 7'b1100111, op_branch = 7'b1100011, op_load = 7'b0000011,
                         op_store = 7'b0100011, op_imm = 7'b0010011, op_op = 7'b0110011;
  typedef struct packed {
    logic                  valid;
    logic [addr_width-1:0] pc;
    logic [word_width-1:0] rs1_data;
    logic [word_width-1:0] rs2_data;
    logic [word_width-1:0] imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [6:0]            opcode;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
  } idex_t;
  logic [word_width-1:0] ifid_inst_q, ifid_inst_d;
  logic [addr_width-1:0] ifid_pc_q, ifid_pc_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic [word_width-1:0] regs_q [32];
  idex_t                 idex_q, idex_d, dec;
  logic [6:0]            opc;
  logic [4:0]            rs1, rs2, rd;
  logic                  is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_imm, is_op;
  logic                  use_rs1, use_rs2, hazard;
  logic [31:0]           imm;
  logic [word_width-1:0] rs1_data, rs2_data;
  assign opc = ifid_inst_q[6:0];
  assign rs1 = ifid_inst_q[19:15];
  assign rs2 = ifid_inst_q[24:20];
  assign rd  = ifid_inst_q[11:7];
  assign is_lui    = opc == op_lui;
  assign is_auipc  = opc == op_auipc;
  assign is_jal    = opc == op_jal;
  assign is_jalr   = opc == op_jalr;
  assign is_branch = opc == op_branch;
  assign is_load   = opc == op_load;
  assign is_store  = opc == op_store;
  assign is_imm    = opc == op_imm;
  assign is_op     = opc == op_op;
  assign use_rs1 = is_jalr | is_branch | is_load | is_store | is_imm | is_op;
  assign use_rs2 = is_branch | is_store | is_op;
  always_comb
    imm = (is_imm | is_load | is_jalr) ? {{20{ifid_inst_q[31]}}, ifid_inst_q[31:20]} :
          is_store  ? {{20{ifid_inst_q[31]}}, ifid_inst_q[31:25], ifid_inst_q[11:7]} :
          is_branch ? {{19{ifid_inst_q[31]}}, ifid_inst_q[31], ifid_inst_q[7], ifid_inst_q[30:25], ifid_inst_q[11:8], 1'b0} :
          (is_lui | is_auipc) ? {ifid_inst_q[31:12], 12'b0} :
          is_jal    ? {{11{ifid_inst_q[31]}}, ifid_inst_q[31], ifid_inst_q[19:12], ifid_inst_q[20], ifid_inst_q[30:21], 1'b0} :
          32'b0;
  // Writeback in the same cycle bypasses the array so ID never sees a stale operand
  assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : regs_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : regs_q[rs2];
  assign hazard = idex_q.valid && idex_q.mem_read && idex_q.rd != 5'd0 &&
                  ((use_rs1 && rs1 == idex_q.rd) || (use_rs2 && rs2 == idex_q.rd));
  assign pc_en    = flush || !hazard;
  assign stall_en = flush;
  assign dec = '{
    valid:     1'b1,
    pc:        ifid_pc_q,
    rs1_data:  rs1_data,
    rs2_data:  rs2_data,
    imm:       imm,
    rs1:       rs1,
    rs2:       rs2,
    rd:        rd,
    funct3:    ifid_inst_q[14:12],
    funct7b5:  ifid_inst_q[30],
    opcode:    opc,
    reg_write: rd != 5'd0 && (is_lui | is_auipc | is_jal | is_jalr | is_load | is_imm | is_op),
    mem_read:  is_load,
    mem_write: is_store,
    branch:    is_branch,
    jump:      is_jal | is_jalr,
    illegal:   !(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_imm | is_op)
  };
  // Flush wins over the hazard: both registers are emptied and IF is free to redirect
  assign idex_d       = (flush || hazard || !ifid_valid_q) ? '0 : dec;
  assign ifid_inst_d  = flush ? nop : hazard ? ifid_inst_q : inst;
  assign ifid_pc_d    = flush ? '0 : hazard ? ifid_pc_q : pc_addr;
  assign ifid_valid_d = flush ? 1'b0 : hazard ? ifid_valid_q : 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ifid_inst_q  <= nop;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
    end else begin
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int r = 0; r < 32; r++) regs_q[r] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs_q[wb_rd] <= wb_data;
    end
  assign id_valid     = idex_q.valid;
  assign id_pc        = idex_q.pc;
  assign id_rs1_data  = idex_q.rs1_data;
  assign id_rs2_data  = idex_q.rs2_data;
  assign id_imm       = idex_q.imm;
  assign id_rs1       = idex_q.rs1;
  assign id_rs2       = idex_q.rs2;
  assign id_rd        = idex_q.rd;
  assign id_funct3    = idex_q.funct3;
  assign id_funct7b5  = idex_q.funct7b5;
  assign id_opcode    = idex_q.opcode;
  assign id_reg_write = idex_q.reg_write;
  assign id_mem_read  = idex_q.mem_read;
  assign id_mem_write = idex_q.mem_write;
  assign id_branch    = idex_q.branch;
  assign id_jump      = idex_q.jump;
  assign id_illegal   = idex_q.illegal;
endmodule

// File: tb/tb_stage_id.sv
// tb_stage_id: directed vectors for stage_id; expected ID/EX contents are queued at issue
// and a negedge monitor pops and compares them whenever id_valid is presented.
module tb_stage_id;
  logic        clk = 0, rst = 1, flush = 0, wb_en = 0;
  logic [31:0] inst = 0, pc_addr = 0, wb_data = 0;
  logic [4:0]  wb_rd = 0;
  logic        pc_en, stall_en, id_valid, id_funct7b5;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_opcode;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal;
  int          tests = 0, fails = 0;
  logic        pe, se, v;
  logic [159:0] exp_q [$];

  localparam logic [31:0] NOP = 32'h0000_0013, LW = 32'h0000_A103, ADD_X2 = 32'h0021_01B3;
  localparam logic [5:0]  RW = 6'b100000, LD = 6'b110000, ST = 6'b001000,
                          BR = 6'b000100, JP = 6'b000010, IL = 6'b000001;

  stage_id dut (
    .clk(clk), .rst(rst), .inst(inst), .pc_addr(pc_addr), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_en(pc_en), .stall_en(stall_en), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_opcode(id_opcode), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jump(id_jump), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] mk(input logic [31:0] pc, imm, d1, d2, i, input logic [5:0] c);
    return {pc, imm, d1, d2, i[19:15], i[24:20], i[11:7], i[14:12], i[30], i[6:0], c};
  endfunction

  function automatic logic [159:0] dut_vec();
    return {id_pc, id_imm, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
            id_opcode, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal};
  endfunction

  task automatic chk(input string n, input logic [159:0] a, e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic cyc(input logic [31:0] i, p, input logic f);
    inst = i; pc_addr = p; flush = f;
    @(negedge clk);
    pe = pc_en; se = stall_en; v = id_valid;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] i, p, input logic [159:0] e);
    exp_q.push_back(e);
    cyc(i, p, 1'b0);
  endtask

  always @(negedge clk) begin
    if (id_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: got %h with no expected entry", dut_vec());
      end else chk($sformatf("sb_pc_%h", id_pc), dut_vec(), exp_q.pop_front());
    end else chk("bubble_zero", dut_vec(), '0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 0;
    inst = $urandom; pc_addr = $urandom;
    repeat (3) @(posedge clk);
    inst = $urandom;
    @(negedge clk);
    chk("rst_outputs", dut_vec(), '0);
    chk("rst_valid", id_valid, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_stall_en", stall_en, 0);
    @(posedge clk); #1 rst = 1;
    // decode and latency
    issue(32'hFFF0_8093, 32'h40, mk(32'h40, 32'hFFFF_FFFF, 0, 0, 32'hFFF0_8093, RW));
    issue(32'hFE00_0EE3, 32'h44, mk(32'h44, 32'hFFFF_FFFC, 0, 0, 32'hFE00_0EE3, BR));
    chk("latency_one_edge", v, 0);
    issue(32'h0001_8233, 32'h48, mk(32'h48, 0, 32'hDEAD_BEEF, 0, 32'h0001_8233, RW));
    chk("latency_two_edges", v, 1);
    // write-through, then x0 stays zero, then x3 persisted and x5 reads 0
    wb_en = 1; wb_rd = 3; wb_data = 32'hDEAD_BEEF;
    issue(32'h0000_0333, 32'h4C, mk(32'h4C, 0, 0, 0, 32'h0000_0333, RW));
    wb_rd = 0; wb_data = 5;
    issue(32'h0051_83B3, 32'h50, mk(32'h50, 0, 32'hDEAD_BEEF, 0, 32'h0051_83B3, RW));
    wb_en = 0;
    // immediate formats and illegal opcode
    issue(32'h0080_00EF, 32'h54, mk(32'h54, 32'h8, 0, 0, 32'h0080_00EF, RW | JP));
    issue(32'h1234_52B7, 32'h58, mk(32'h58, 32'h1234_5000, 0, 32'hDEAD_BEEF, 32'h1234_52B7, RW));
    issue(32'hFE50_AC23, 32'h5C, mk(32'h5C, 32'hFFFF_FFF8, 0, 0, 32'hFE50_AC23, ST));
    issue(32'hFFFF_F497, 32'h60, mk(32'h60, 32'hFFFF_F000, 0, 0, 32'hFFFF_F497, RW));
    issue(32'hFFC1_8067, 32'h64, mk(32'h64, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 32'hFFC1_8067, JP));
    issue(32'h0000_007F, 32'h68, mk(32'h68, 0, 0, 0, 32'h0000_007F, IL));
    // load-use: lw x2 then add x3,x2,x2 stalls exactly once
    issue(LW, 32'h6C, mk(32'h6C, 0, 0, 0, LW, LD));
    issue(ADD_X2, 32'h70, mk(32'h70, 0, 0, 0, ADD_X2, RW));
    chk("lu_pre_pc_en", pe, 1);
    issue(NOP, 32'h74, mk(32'h74, 0, 0, 0, NOP, 0));
    chk("lu_stall_pc_en", pe, 0);
    chk("lu_stall_valid", v, 1);
    cyc(NOP, 32'h74, 1'b0);
    chk("lu_bubble_pc_en", pe, 1);
    chk("lu_bubble_valid", v, 0);
    // no stall when sources do not match, nor on an unused rs2 field
    issue(LW, 32'h78, mk(32'h78, 0, 0, 0, LW, LD));
    chk("lu_resume_pc_en", pe, 1);
    issue(32'h0052_01B3, 32'h7C, mk(32'h7C, 0, 0, 0, 32'h0052_01B3, RW));
    issue(LW, 32'h80, mk(32'h80, 0, 0, 0, LW, LD));
    chk("nostall_x4_x5", pe, 1);
    issue(32'h0020_0413, 32'h84, mk(32'h84, 32'h2, 0, 0, 32'h0020_0413, RW));
    issue(NOP, 32'h88, mk(32'h88, 0, 0, 0, NOP, 0));
    chk("nostall_rs2_unused", pe, 1);
    // flush: the instruction sitting in IF/ID is killed, two bubbles follow
    cyc(32'h0050_0413, 32'h8C, 1'b0);
    cyc(32'h0000_0333, 32'h90, 1'b1);
    chk("flush_stall_en", se, 1);
    chk("flush_pc_en", pe, 1);
    issue(32'h0000_0333, 32'h100, mk(32'h100, 0, 0, 0, 32'h0000_0333, RW));
    chk("flush_bubble1", v, 0);
    chk("flush_stall_en_off", se, 0);
    issue(NOP, 32'h104, mk(32'h104, 0, 0, 0, NOP, 0));
    chk("flush_bubble2", v, 0);
    issue(NOP, 32'h108, mk(32'h108, 0, 0, 0, NOP, 0));
    chk("flush_target_valid", v, 1);
    // flush together with a load-use hazard
    issue(LW, 32'h10C, mk(32'h10C, 0, 0, 0, LW, LD));
    cyc(ADD_X2, 32'h110, 1'b0);
    cyc(NOP, 32'h114, 1'b1);
    chk("flush_hz_pc_en", pe, 1);
    chk("flush_hz_stall_en", se, 1);
    issue(NOP, 32'h200, mk(32'h200, 0, 0, 0, NOP, 0));
    chk("flush_hz_bubble1", v, 0);
    issue(NOP, 32'h204, mk(32'h204, 0, 0, 0, NOP, 0));
    chk("flush_hz_bubble2", v, 0);
    issue(NOP, 32'h208, mk(32'h208, 0, 0, 0, NOP, 0));
    chk("flush_hz_resume", v, 1);
    chk("flush_hz_resume_pc_en", pe, 1);
    // asynchronous reset in the middle of a stall
    issue(LW, 32'h20C, mk(32'h20C, 0, 0, 0, LW, LD));
    cyc(ADD_X2, 32'h210, 1'b0);
    inst = NOP; pc_addr = 32'h214;
    @(negedge clk);
    chk("arst_pre_stall", pc_en, 0);
    #1 rst = 0;
    #1;
    chk("arst_outputs", dut_vec(), '0);
    chk("arst_valid", id_valid, 0);
    chk("arst_pc_en", pc_en, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1;
    issue(32'h0050_0413, 32'h300, mk(32'h300, 32'h5, 0, 0, 32'h0050_0413, RW));
    chk("arst_restart_pc_en", pe, 1);
    issue(NOP, 32'h304, mk(32'h304, 0, 0, 0, NOP, 0));
    chk("arst_restart_bubble", v, 0);
    cyc(NOP, 32'h308, 1'b0);
    chk("arst_restart_valid", v, 1);
    chk("arst_no_stall", pe, 1);
    repeat (3) cyc(NOP, 32'h30C, 1'b1);
    flush = 0;
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
